// File: rtl/lsu_mem_master.sv
// lsu_mem_master - CPU-side initiator for the single-cycle data RAM port.
//
// Takes load/store requests from the execute stage over a valid/ready
// handshake, drives the RAM strobes/address/data, and returns a one-cycle
// response pulse with the extended load result. Byte and halfword stores are
// done as a word read-modify-write because the RAM only writes full words.
//
// Optional feature macro: LSU_STRICT_ALIGN_EN
//   defined   : misaligned half/word requests and size 11 return resp_error
//               after one cycle with no RAM access.
//   undefined : no alignment errors; half ignores addr[0], word ignores
//               addr[1:0], size 11 behaves as word, resp_error tied 0.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/size/unsigned      store flag, 00 byte 01 half 10 word, zero-ext
//   req_addr, req_wdata          byte address, store data (sub-word in LSBs)
//   resp_valid/error/rdata       completion pulse, error flag, load result
//   mem_addr/read/write/wdata    word-aligned RAM port, strobes decoded
//   mem_rdata                    combinational RAM read data
//
// state   | meaning
// IDLE    | ready for a request
// LOAD    | read strobe, capture extended load data
// RMW_RD  | read strobe, merge store lane into the old word
// STORE   | write strobe with the full word
// RESP    | one-cycle response pulse
module lsu_mem_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_STORE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    // Holds store data, then the merged word after RMW_RD.
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_d;

    logic [1:0]          size_eff;
    logic                req_err;
    logic [1:0]          lane;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;

`ifdef LSU_STRICT_ALIGN_EN
    logic                err_q;
    assign size_eff = req_size;
    assign req_err  = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign resp_error = err_q;
`else
    assign size_eff   = (req_size == 2'b11) ? 2'b10 : req_size;
    assign req_err    = 1'b0;
    assign resp_error = 1'b0;
`endif

    // Byte offset of the addressed lane; half ignores addr[0], word uses lane 0.
    always_comb begin
        case (size_q)
            2'b00:   lane = addr_q[1:0];
            2'b01:   lane = {addr_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00)
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane, 3'b000} +: 16] = wdata_q[15:0];
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef LSU_STRICT_ALIGN_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef LSU_STRICT_ALIGN_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef LSU_STRICT_ALIGN_EN
        err_d      = err_q;
`else
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = size_eff;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if (req_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_write)
                        state_d = S_LOAD;
                    else if (size_eff == 2'b10)
                        state_d = S_STORE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                wdata_d = merged;
                state_d = S_STORE;
            end
            S_STORE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state so strobes drop as soon as reset hits.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        mem_read   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        mem_write  = (state_q == S_STORE);
        mem_addr   = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata  = mem_write ? wdata_q : '0;
    end

endmodule
